// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch stage feeding a one-entry instruction register.
// Optional feature macro FETCH_MISALIGN_CHECK_EN traps misaligned redirects in a sticky ERROR state.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        fetch_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: imem_req/imem_addr stay stable until exactly one imem_rvalid pulse answers
  // them; an instruction transfers to decode on a cycle where ir_valid and ir_ready are both 1.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] redirect_target;
  logic        redirect_bad;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_target = redirect_pc;
  assign redirect_bad    = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fetch_err       = (state == ERROR);
`else
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];
  assign redirect_target     = {redirect_pc[31:2], 2'b00};
  assign redirect_bad        = 1'b0;
  assign fetch_err           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      pc          <= '0;
      instruction <= '0;
      ir_valid    <= 1'b0;
    end else if (redirect_bad) begin
      // Fatal target: drop any same-cycle response or handshake and park until reset.
      state    <= ERROR;
      ir_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_target;
            // Without a response this cycle it is still owed and must be swallowed.
            if (!imem_rvalid) state <= DRAIN;
          end else if (imem_rvalid) begin
            instruction <= imem_rdata;
            pc          <= fetch_pc;
            ir_valid    <= 1'b1;
            fetch_pc    <= fetch_pc + 32'd4;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_target;
            ir_valid <= 1'b0;
            state    <= FETCH;
          end else if (ir_ready) begin
            ir_valid <= 1'b0;
            state    <= FETCH;
          end
        end
        DRAIN: begin
          if (redirect_valid) fetch_pc <= redirect_target;
          // Leaving needs the stale response even when a new redirect lands with it.
          if (imem_rvalid) state <= FETCH;
        end
        default: begin
          ir_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = (state == FETCH) && !rst;
  assign imem_addr = fetch_pc;
  assign dbg_state = state;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized bench for instr_fetch with a memory model, an architectural
// next-pc reference model feeding an expected queue, and a handshake monitor.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MISALIGN_TRAP = 1'b1;
`else
  localparam bit MISALIGN_TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .instruction    (instruction),
    .pc             (pc),
    .fetch_err      (fetch_err),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, required finish before 1ms");
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- shared state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] next_pc;
  bit          model_err;
  bit          mem_lat_rand = 1'b0;
  int          mem_lat_fix = 1;
  bit          wd_en = 1'b1;
  bit          busy;
  logic [31:0] m_addr;
  int          lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h1234_50B7;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic bit bad_redir(input logic [31:0] t);
    return MISALIGN_TRAP && (t[1:0] != 2'b00);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- instruction memory model ----------------
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    busy        = 1'b0;
    m_addr      = '0;
    lat         = 0;
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (rst) begin
        busy = 1'b0;
      end else begin
        if (!busy && imem_req) begin
          busy   = 1'b1;
          m_addr = imem_addr;
          lat    = mem_lat_rand ? $urandom_range(0, 3) : mem_lat_fix;
        end else if (busy && imem_req) begin
          check("req_addr_stable", imem_addr, m_addr);
        end
        if (busy) begin
          if (lat == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(m_addr);
            busy        = 1'b0;
          end else begin
            lat--;
          end
        end
      end
    end
  end

  // ---------------- reference model: architectural fetch stream ----------------
  // Each accepted instruction must be the next sequential pc, unless a redirect
  // happened since the previous acceptance; a same-cycle handshake counts first.
  initial begin
    next_pc   = RESET_PC;
    model_err = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (rst) begin
        next_pc   = RESET_PC;
        model_err = 1'b0;
        exp_q.delete();
      end else if (!model_err) begin
        if (ir_valid && ir_ready) begin
          exp_q.push_back(next_pc);
          next_pc = next_pc + 32'd4;
        end
        if (redirect_valid) begin
          if (bad_redir(redirect_pc)) model_err = 1'b1;
          else next_pc = {redirect_pc[31:2], 2'b00};
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit          prev_hold = 1'b0;
  bit          req_due = 1'b0;
  int          idle_cnt = 0;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;
  logic [31:0] e;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
        req_due   = 1'b0;
        idle_cnt  = 0;
      end else begin
        if (req_due) check("req_after_handshake", 32'(imem_req), 32'd1);
        req_due = 1'b0;
        if (prev_hold) begin
          check("hold_ir_valid", 32'(ir_valid), 32'd1);
          check("hold_pc_stable", pc, prev_pc);
          check("hold_instr_stable", instruction, prev_instr);
        end
        if (ir_valid && ir_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_instr: got pc %h, required no instruction", pc);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc", pc, e);
            check("sb_instr", instruction, mem_word(e));
          end
          req_due  = !(redirect_valid && bad_redir(redirect_pc));
          idle_cnt = 0;
        end else if (wd_en) begin
          idle_cnt++;
          if (idle_cnt == 200) begin
            n_vec++;
            n_err++;
            $display("FAIL watchdog: got no handshake in %0d cycles, required one", idle_cnt);
            idle_cnt = 0;
          end
        end
        prev_hold  = ir_valid && !ir_ready && !redirect_valid;
        prev_pc    = pc;
        prev_instr = instruction;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ir(input string name);
    int n;
    n = 0;
    while (!ir_valid && n < 30) begin
      step();
      n++;
    end
    if (!ir_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got ir_valid 0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic handshake();
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] r;
  bit          saw_rv;
  int          n;

  initial begin
    rst            = 1'b1;
    ir_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    step();
    step();
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_instruction", instruction, 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);

    // First request right after reset release, then first instruction.
    rst = 1'b0;
    #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, RESET_PC);
    wait_ir("first_ir");
    check("first_instr", instruction, 32'h1234_50B7);
    check("first_pc", pc, 32'd0);
    check("hold_no_req", 32'(imem_req), 32'd0);
    check("next_fetch_pc", imem_addr, 32'd4);

    // Decode stalls 5 cycles, then accepts; request to 4 follows next cycle.
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_pc", pc, 32'd0);
      check("stall_instr", instruction, 32'h1234_50B7);
      check("stall_no_req", 32'(imem_req), 32'd0);
    end
    handshake();
    check("resume_req", 32'(imem_req), 32'd1);
    check("resume_addr", imem_addr, 32'd4);

    // Redirect while the request to 8 is outstanding: drain stale data.
    wait_ir("ir_pc4");
    check("ir_pc4_pc", pc, 32'd4);
    mem_lat_fix = 3;
    handshake();
    check("req8_req", 32'(imem_req), 32'd1);
    check("req8_addr", imem_addr, 32'd8);
    redirect(32'h0000_0100);
    mem_lat_fix = 1;
    check("drain_no_req", 32'(imem_req), 32'd0);
    saw_rv = 1'b0;
    n = 0;
    while (!imem_req && n < 10) begin
      check("drain_no_ir", 32'(ir_valid), 32'd0);
      if (imem_rvalid) saw_rv = 1'b1;
      step();
      n++;
    end
    check("drain_saw_stale", 32'(saw_rv), 32'd1);
    check("drain_next_addr", imem_addr, 32'h0000_0100);

    // Redirect on the same cycle as the response: no capture.
    n = 0;
    while (!(imem_rvalid && imem_req) && n < 10) begin
      step();
      n++;
    end
    check("same_cycle_rvalid_seen", 32'(imem_rvalid && imem_req), 32'd1);
    redirect(32'h0000_0200);
    check("same_cycle_no_ir", 32'(ir_valid), 32'd0);
    check("same_cycle_req", 32'(imem_req), 32'd1);
    check("same_cycle_addr", imem_addr, 32'h0000_0200);

    // Address wrap at the top of memory.
    redirect(32'hFFFF_FFFC);
    wait_ir("wrap_ir");
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_next_addr", imem_addr, 32'd0);
    handshake();
    check("wrap_req", 32'(imem_req), 32'd1);
    check("wrap_req_addr", imem_addr, 32'd0);

    // Randomized traffic.
    mem_lat_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      ir_ready = $urandom_range(0, 1);
      r        = $urandom;
      if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFF0 | (r & 32'h0000_000F);
      if (MISALIGN_TRAP) r[1:0] = 2'b00;
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = r;
      step();
    end
    rst            = 1'b0;
    redirect_valid = 1'b0;
    ir_ready       = 1'b1;
    for (int i = 0; i < 10; i++) step();
    ir_ready = 1'b0;
    wd_en    = 1'b0;

    // Misaligned redirect.
    redirect(32'h0000_0102);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("misalign_err", 32'(fetch_err), 32'd1);
    for (int i = 0; i < 10; i++) begin
      ir_ready = $urandom_range(0, 1);
      step();
      check("err_no_req", 32'(imem_req), 32'd0);
      check("err_no_ir", 32'(ir_valid), 32'd0);
      check("err_sticky", 32'(fetch_err), 32'd1);
    end
    ir_ready = 1'b0;
    rst = 1'b1;
    step();
    check("err_cleared", 32'(fetch_err), 32'd0);
    rst = 1'b0;
    #1;
    check("err_reset_req", 32'(imem_req), 32'd1);
`else
    check("misalign_addr", imem_addr, 32'h0000_0100);
    check("misalign_no_err", 32'(fetch_err), 32'd0);
    wait_ir("misalign_ir");
    check("misalign_pc", pc, 32'h0000_0100);
    handshake();
`endif
    step();
    step();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
